mem_stage_ctrl: RTL and testbench

- Sequences the MEM stage of the 32-bit pipeline; sits between the EX→MEM pipeline register and the MEM→WB register.
- Runs each load/store as a req/ready handshake to a variable-latency data memory and stalls the upstream pipeline until the access completes.
- Resolves branches (branch & zero) and drives the PC-select and flush signals.
- Produces the registered MEM→WB payload.

---
 rtl/mem_stage_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer: runs load/store handshakes against a variable-latency data memory,
// stalls the upstream pipeline while an access is in flight, resolves branches, and registers MEM->WB.
module mem_stage_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] st_val_in,
    input  logic [4:0]  dest_in,
    input  logic        zero_in,
    input  logic        branch_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic        pc_src,
    output logic        flush,
    output logic        wb_en,
    output logic        mem_to_reg,
    output logic [31:0] alu_res,
    output logic [31:0] mem_data,
    output logic [4:0]  dest,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             is_load, lat_wb, aborted;
    logic [4:0]       lat_dest;
    logic [31:0]      rdata_q;
    logic             op, timeout_hit;

    assign op          = mem_r_en_in | mem_w_en_in;
    assign timeout_hit = (state == ACCESS) && !mem_ready && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (op) next_state = ACCESS;
            ACCESS:  if (mem_ready || timeout_hit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Branch resolution is only meaningful when no memory access is being started.
    always_comb begin
        mem_req = (state == ACCESS);
        stall   = ((state == IDLE) && op) || (state == ACCESS);
        pc_src  = (state == IDLE) && branch_in && zero_in && !op;
        flush   = pc_src;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            is_load    <= 1'b0;
            lat_wb     <= 1'b0;
            lat_dest   <= '0;
            aborted    <= 1'b0;
            rdata_q    <= '0;
            err        <= 1'b0;
            wb_en      <= 1'b0;
            mem_to_reg <= 1'b0;
            alu_res    <= '0;
            mem_data   <= '0;
            dest       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (op) begin
                        mem_addr  <= alu_res_in;
                        mem_wdata <= st_val_in;
                        mem_we    <= mem_w_en_in;
                        is_load   <= mem_r_en_in & ~mem_w_en_in;
                        lat_wb    <= wb_en_in;
                        lat_dest  <= dest_in;
                        cnt       <= '0;
                        aborted   <= 1'b0;
                        wb_en     <= 1'b0;
                    end else begin
                        wb_en      <= wb_en_in;
                        mem_to_reg <= 1'b0;
                        alu_res    <= alu_res_in;
                        dest       <= dest_in;
                    end
                end
                ACCESS: begin
                    wb_en <= 1'b0;
                    if (mem_ready) begin
                        if (is_load) rdata_q <= mem_rdata;
                    end else if (timeout_hit) begin
                        err     <= 1'b1;
                        aborted <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    alu_res <= mem_addr;
                    dest    <= lat_dest;
                    if (aborted) begin
                        wb_en      <= 1'b0;
                        mem_to_reg <= 1'b0;
                        mem_data   <= '0;
                    end else if (is_load) begin
                        wb_en      <= lat_wb;
                        mem_to_reg <= 1'b1;
                        mem_data   <= rdata_q;
                    end else begin
                        wb_en      <= lat_wb;
                        mem_to_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed and random instruction streams against a
// transaction-level model of stall length, memory handshake and MEM->WB writeback.
module tb_mem_stage_ctrl;

    localparam int TIMEOUT = 16;
    localparam int NEVER   = 99;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, zero_in, branch_in;
    logic [31:0] alu_res_in, st_val_in, mem_rdata;
    logic [4:0]  dest_in;
    logic        mem_ready;
    logic        mem_req, mem_we, stall, pc_src, flush, wb_en, mem_to_reg, err;
    logic [31:0] mem_addr, mem_wdata, alu_res, mem_data;
    logic [4:0]  dest;

    int checks = 0;
    int errors = 0;

    // Expected architectural view of MEM->WB after an instruction leaves the stage
    bit          exp_err;
    logic [31:0] mdata;
    bit          p_wb, p_m2r, p_chk_m2r;
    logic [31:0] p_alu, p_md;
    logic [4:0]  p_dest;

    mem_stage_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_res_in(alu_res_in), .st_val_in(st_val_in), .dest_in(dest_in),
        .zero_in(zero_in), .branch_in(branch_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .stall(stall), .pc_src(pc_src), .flush(flush),
        .wb_en(wb_en), .mem_to_reg(mem_to_reg), .alu_res(alu_res), .mem_data(mem_data),
        .dest(dest), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_pend(input bit wb, input bit m2r, input bit cm2r,
                            input logic [31:0] a, input logic [31:0] md, input logic [4:0] d);
        p_wb = wb; p_m2r = m2r; p_chk_m2r = cm2r; p_alu = a; p_md = md; p_dest = d;
    endtask

    // Present one EX/MEM instruction, act as the memory (ready after w wait cycles),
    // and hold it until the stage releases it.
    task automatic exec(input bit ld, input bit st, input bit wb, input logic [31:0] a,
                        input logic [31:0] sv, input logic [4:0] d, input bit br, input bit z,
                        input int w, input logic [31:0] rd);
        bit op;
        bit abort;
        bit s;
        int cyc;
        int reqs;
        int stalls;
        int acc;
        int exp_reqs;
        op = ld | st;
        abort = op && (w >= TIMEOUT);
        exp_reqs = !op ? 0 : (abort ? TIMEOUT : w + 1);
        cyc = 0; reqs = 0; stalls = 0; acc = 0;
        mem_r_en_in = ld; mem_w_en_in = st; wb_en_in = wb; alu_res_in = a;
        st_val_in = sv; dest_in = d; branch_in = br; zero_in = z;
        forever begin
            if (mem_req) begin
                mem_ready = (acc == w);
                mem_rdata = (acc == w) ? rd : $urandom;
                acc++;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            @(negedge clk);
            if (cyc == 0) begin
                chk("wb_en", 32'(wb_en), 32'(p_wb));
                chk("alu_res", alu_res, p_alu);
                chk("dest", 32'(dest), 32'(p_dest));
                chk("mem_data", mem_data, p_md);
                if (p_chk_m2r) chk("mem_to_reg", 32'(mem_to_reg), 32'(p_m2r));
                chk("err", 32'(err), 32'(exp_err));
                chk("pc_src", 32'(pc_src), 32'(br & z & ~op));
                chk("flush", 32'(flush), 32'(br & z & ~op));
            end else begin
                chk("bubble_wb_en", 32'(wb_en), 32'(0));
            end
            if (mem_req) begin
                reqs++;
                chk("mem_addr", mem_addr, a);
                chk("mem_we", 32'(mem_we), 32'(st));
                if (st) chk("mem_wdata", mem_wdata, sv);
            end
            if (stall) stalls++;
            s = stall;
            @(posedge clk);
            #1;
            cyc++;
            if (!s) break;
            if (cyc > TIMEOUT + 8) begin
                chk("cycle_budget", 32'(cyc), 32'(TIMEOUT + 8));
                break;
            end
        end
        mem_ready = 1'b0;
        chk("mem_req_cycles", 32'(reqs), 32'(exp_reqs));
        chk("stall_cycles", 32'(stalls), 32'(op ? exp_reqs + 1 : 0));
        if (!op) begin
            set_pend(wb, 1'b0, 1'b1, a, mdata, d);
        end else if (abort) begin
            exp_err = 1'b1;
            mdata = '0;
            set_pend(1'b0, 1'b0, 1'b0, a, 32'h0, d);
        end else if (ld && !st) begin
            mdata = rd;
            set_pend(wb, 1'b1, 1'b1, a, rd, d);
        end else begin
            set_pend(wb, 1'b0, 1'b1, a, mdata, d);
        end
    endtask

    initial begin
        rst = 1'b1;
        wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; zero_in = 0; branch_in = 0;
        alu_res_in = '0; st_val_in = '0; dest_in = '0; mem_rdata = '0; mem_ready = 0;
        exp_err = 0; mdata = '0;
        set_pend(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0);
        #2;
        chk("rst_mem_req", 32'(mem_req), 32'(0));
        chk("rst_stall", 32'(stall), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_data", mem_data, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // zero-wait load, ALU op, load back to back
        exec(1, 0, 1, 32'h100, 32'h0, 5'd7, 0, 0, 0, 32'hDEADBEEF);
        exec(0, 0, 1, 32'h5, 32'h0, 5'd3, 0, 0, 0, 32'h0);
        exec(1, 0, 1, 32'h104, 32'h0, 5'd9, 0, 0, 1, 32'hCAFEF00D);
        // store with 3 wait cycles
        exec(0, 1, 0, 32'h40, 32'h12345678, 5'd0, 0, 0, 3, 32'h0);
        // branches taken / not taken
        exec(0, 0, 0, 32'h0, 32'h0, 5'd0, 1, 1, 0, 32'h0);
        exec(0, 0, 0, 32'h1, 32'h0, 5'd0, 1, 0, 0, 32'h0);
        // read and write together behave as a store
        exec(1, 1, 1, 32'h80, 32'hA5A5A5A5, 5'd4, 0, 0, 2, 32'h11111111);

        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = $urandom_range(0, 3);
            exec(kind == 1 || kind == 3, kind >= 2, 1'($urandom_range(0, 1)), $urandom, $urandom,
                 5'($urandom_range(0, 31)), kind == 0 && $urandom_range(0, 1) == 1,
                 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom);
        end

        // timeout, then ALU op passes while err stays set
        exec(1, 0, 1, 32'h300, 32'h0, 5'd12, 0, 0, NEVER, 32'h0);
        exec(0, 0, 1, 32'h77, 32'h0, 5'd6, 0, 0, 0, 32'h0);
        exec(0, 0, 0, 32'h78, 32'h0, 5'd0, 0, 0, 0, 32'h0);

        // asynchronous reset in the middle of an access
        mem_r_en_in = 1; wb_en_in = 1; alu_res_in = 32'h200; dest_in = 5'd2; mem_ready = 0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_mem_req", 32'(mem_req), 32'(1));
        #2;
        rst = 1'b1; mem_r_en_in = 0; wb_en_in = 0;
        #1;
        chk("arst_mem_req", 32'(mem_req), 32'(0));
        chk("arst_stall", 32'(stall), 32'(0));
        chk("arst_err", 32'(err), 32'(0));
        chk("arst_mem_addr", mem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_err = 0; mdata = '0;
        set_pend(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 5'd0);

        exec(0, 0, 1, 32'h55, 32'h0, 5'd8, 0, 0, 0, 32'h0);
        exec(1, 0, 1, 32'h60, 32'h0, 5'd10, 0, 0, 0, 32'h0BADF00D);
        exec(0, 0, 0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
